// File: rtl/qenc_dqp_fsm.sv
// cu_qp_delta binarizer: TU prefix (cMax=5, context coded), EG0 suffix and
// sign (bypass), streamed to the CABAC engine over a valid/ready handshake.
module qenc_dqp_fsm #(
    parameter logic [9:0] CTX_DQP_BASE = 10'd96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dqp_start,
    input  logic       cu_qp_delta_enabled_flag,
    input  logic [6:0] CuQpDeltaVal,
    input  logic [1:0] slice_type,
    input  logic       cabac_init_flag,
    output logic [9:0] ctx_dqp_addr,
    output logic       ctx_dqp_addr_vld,
    output logic       enc_run_dqp,
    input  logic       enc_rdy,
    output logic       EPMode_dqp,
    output logic       binVal,
    output logic       dqp_done_intr
);

    typedef enum logic [2:0] {
        IDLE, PREFIX, SUF_UNARY, SUF_BITS, SIGN, DONE
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] absv_q, absv_d;
    logic       sgn_q, sgn_d;
    logic [1:0] init_q, init_d;
    logic [2:0] idx_q, idx_d;
    logic [6:0] val_q, val_d;
    logic [2:0] k_q, k_d;
    logic [1:0] init_type;
    logic [6:0] step;

    // initType derived from the slice type and cabac_init_flag at start
    always_comb begin
        init_type = 2'd0;
        case (slice_type)
            2'd0:    init_type = cabac_init_flag ? 2'd1 : 2'd2;
            2'd1:    init_type = cabac_init_flag ? 2'd2 : 2'd1;
            default: init_type = 2'd0;
        endcase
    end

    // State register and captured operands; reset abandons any sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            absv_q  <= '0;
            sgn_q   <= 1'b0;
            init_q  <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            absv_q  <= absv_d;
            sgn_q   <= sgn_d;
            init_q  <= init_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            k_q     <= k_d;
        end
    end

    // Next state, bin generation and handshake outputs; advance on transfer only
    always_comb begin
        state_d          = state_q;
        absv_d           = absv_q;
        sgn_d            = sgn_q;
        init_d           = init_q;
        idx_d            = idx_q;
        val_d            = val_q;
        k_d              = k_q;
        ctx_dqp_addr     = '0;
        ctx_dqp_addr_vld = 1'b0;
        enc_run_dqp      = 1'b0;
        EPMode_dqp       = 1'b0;
        binVal           = 1'b0;
        dqp_done_intr    = 1'b0;
        step             = 7'd1 << k_q;
        unique case (state_q)
            IDLE: begin
                if (dqp_start) begin
                    absv_d  = CuQpDeltaVal[6] ? (~CuQpDeltaVal + 7'd1)
                                              : CuQpDeltaVal;
                    sgn_d   = CuQpDeltaVal[6];
                    init_d  = init_type;
                    idx_d   = '0;
                    state_d = cu_qp_delta_enabled_flag ? PREFIX : DONE;
                end
            end
            PREFIX: begin
                enc_run_dqp      = 1'b1;
                ctx_dqp_addr_vld = 1'b1;
                binVal           = absv_q > {4'd0, idx_q};
                ctx_dqp_addr     = CTX_DQP_BASE + {7'd0, init_q, 1'b0}
                                 + {9'd0, idx_q != 3'd0};
                if (enc_rdy) begin
                    if (!binVal || idx_q == 3'd4) begin
                        if (absv_q >= 7'd5) begin
                            val_d   = absv_q - 7'd5;
                            k_d     = '0;
                            state_d = SUF_UNARY;
                        end else if (absv_q != 7'd0) begin
                            state_d = SIGN;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            SUF_UNARY: begin
                enc_run_dqp = 1'b1;
                EPMode_dqp  = 1'b1;
                binVal      = val_q >= step;
                if (enc_rdy) begin
                    if (binVal) begin
                        val_d = val_q - step;
                        k_d   = k_q + 3'd1;
                    end else if (k_q == 3'd0) begin
                        state_d = SIGN;
                    end else begin
                        k_d     = k_q - 3'd1;
                        state_d = SUF_BITS;
                    end
                end
            end
            SUF_BITS: begin
                enc_run_dqp = 1'b1;
                EPMode_dqp  = 1'b1;
                binVal      = val_q[k_q];
                if (enc_rdy) begin
                    if (k_q == 3'd0) state_d = SIGN;
                    else             k_d     = k_q - 3'd1;
                end
            end
            SIGN: begin
                enc_run_dqp = 1'b1;
                EPMode_dqp  = 1'b1;
                binVal      = sgn_q;
                if (enc_rdy) state_d = DONE;
            end
            DONE: begin
                dqp_done_intr = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_qenc_dqp_fsm.sv
// Self-checking bench for qenc_dqp_fsm: directed scenarios plus random
// deltas checked against a behavioural binarization model.
module tb_qenc_dqp_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dqp_start = 1'b0;
    logic       cu_qp_delta_enabled_flag = 1'b0;
    logic [6:0] CuQpDeltaVal = '0;
    logic [1:0] slice_type = '0;
    logic       cabac_init_flag = 1'b0;
    logic [9:0] ctx_dqp_addr;
    logic       ctx_dqp_addr_vld;
    logic       enc_run_dqp;
    logic       enc_rdy = 1'b1;
    logic       EPMode_dqp;
    logic       binVal;
    logic       dqp_done_intr;

    int n_assert = 0;
    int n_fail = 0;

    logic [11:0] obs_q[$];
    logic [11:0] exp_q[$];
    int ndone, nrun, done_cyc, stall_err, flag_err, timeout;

    qenc_dqp_fsm #(.CTX_DQP_BASE(10'd96)) dut (
        .clk(clk), .rst(rst), .dqp_start(dqp_start),
        .cu_qp_delta_enabled_flag(cu_qp_delta_enabled_flag),
        .CuQpDeltaVal(CuQpDeltaVal), .slice_type(slice_type),
        .cabac_init_flag(cabac_init_flag), .ctx_dqp_addr(ctx_dqp_addr),
        .ctx_dqp_addr_vld(ctx_dqp_addr_vld), .enc_run_dqp(enc_run_dqp),
        .enc_rdy(enc_rdy), .EPMode_dqp(EPMode_dqp), .binVal(binVal),
        .dqp_done_intr(dqp_done_intr)
    );

    always #5 clk = ~clk;

    // bin code: {context-coded, address (0 for bypass), value}
    function automatic logic [11:0] mk(input bit c, input int a, input bit b);
        logic [9:0] a10;
        a10 = c ? 10'(a) : 10'd0;
        return {c, a10, b};
    endfunction

    // reference binarization straight from the syntax-element definition
    function automatic void build_exp(input int v, input int st,
                                      input bit cif, input bit en);
        int a, p, it, base, n, k;
        exp_q.delete();
        if (!en) return;
        a = (v >= 64) ? 128 - v : v;
        it = (st == 1) ? (cif ? 2 : 1) : (st == 0) ? (cif ? 1 : 2) : 0;
        base = 96 + 2 * it;
        p = (a < 5) ? a : 5;
        for (int i = 0; i < p; i++) exp_q.push_back(mk(1, base + (i > 0 ? 1 : 0), 1));
        if (p < 5) exp_q.push_back(mk(1, base + (p > 0 ? 1 : 0), 0));
        if (a >= 5) begin
            n = a - 5;
            k = 0;
            while (n >= (1 << k)) begin
                exp_q.push_back(mk(0, 0, 1));
                n -= (1 << k);
                k++;
            end
            exp_q.push_back(mk(0, 0, 0));
            for (int j = k - 1; j >= 0; j--) exp_q.push_back(mk(0, 0, 1'((n >> j) & 1)));
        end
        if (a > 0) exp_q.push_back(mk(0, 0, v >= 64));
    endfunction

    // drives one start, then monitors the stream; mode 0=ready,1=toggle,2=random
    task automatic run_seq(input int v, input int st, input bit cif, input bit en,
                           input int mode, input int abort_at);
        logic [11:0] hold, cur;
        bit stalled, tog;
        obs_q.delete();
        ndone = 0; nrun = 0; done_cyc = -1; stall_err = 0; flag_err = 0;
        timeout = 1; stalled = 0; tog = 0; hold = '0;
        @(negedge clk);
        dqp_start = 1'b1;
        CuQpDeltaVal = 7'(v);
        slice_type = 2'(st);
        cabac_init_flag = cif;
        cu_qp_delta_enabled_flag = en;
        @(negedge clk);
        dqp_start = 1'b0;
        CuQpDeltaVal = 7'($urandom);
        slice_type = 2'($urandom);
        cabac_init_flag = 1'($urandom);
        cu_qp_delta_enabled_flag = 1'($urandom);
        for (int cyc = 0; cyc < 400; cyc++) begin
            cur = {ctx_dqp_addr_vld, ctx_dqp_addr_vld ? ctx_dqp_addr : 10'd0, binVal};
            if (!enc_run_dqp && (ctx_dqp_addr_vld || EPMode_dqp)) flag_err++;
            if (enc_run_dqp && (ctx_dqp_addr_vld == EPMode_dqp)) flag_err++;
            if (enc_run_dqp && dqp_done_intr) flag_err++;
            if (stalled && (!enc_run_dqp || cur != hold)) stall_err++;
            if (enc_run_dqp) nrun++;
            if (dqp_done_intr) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (abort_at >= 0 && obs_q.size() == abort_at) begin
                timeout = 0;
                dqp_start = 1'b0;
                return;
            end
            if (ndone > 0 && !dqp_done_intr) begin
                timeout = 0;
                break;
            end
            if (mode == 0) enc_rdy = 1'b1;
            else if (mode == 1) enc_rdy = tog;
            else enc_rdy = 1'($urandom);
            tog = !tog;
            if (enc_run_dqp && enc_rdy) obs_q.push_back(cur);
            stalled = enc_run_dqp && !enc_rdy;
            hold = cur;
            dqp_start = enc_run_dqp ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        dqp_start = 1'b0;
        enc_rdy = 1'b1;
    endtask

    task automatic test_reset;
        #3;
        n_assert++;
        if ({ctx_dqp_addr, ctx_dqp_addr_vld, enc_run_dqp, EPMode_dqp, binVal,
             dqp_done_intr} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {ctx_dqp_addr,
                     ctx_dqp_addr_vld, enc_run_dqp, EPMode_dqp, binVal, dqp_done_intr});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_assert++;
        if (enc_run_dqp !== 1'b0 || dqp_done_intr !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got run=%0b done=%0b want 0 0",
                     enc_run_dqp, dqp_done_intr);
        end
    endtask

    task automatic test_zero_i;
        exp_q.delete();
        exp_q.push_back(mk(1, 96, 0));
        run_seq(0, 2, 0, 1, 0, -1);
        n_assert++;
        if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL zero_bins: got n=%0d b0=%h want n=1 b0=%h",
                     obs_q.size(), obs_q.size() ? obs_q[0] : 12'h0, exp_q[0]);
        end
        n_assert++;
        if (done_cyc !== 1 || ndone !== 1) begin
            n_fail++;
            $display("FAIL zero_done: got cyc=%0d n=%0d want cyc=1 n=1", done_cyc, ndone);
        end
        n_assert++;
        if (flag_err !== 0 || timeout !== 0) begin
            n_fail++;
            $display("FAIL zero_flags: got err=%0d to=%0d want 0 0", flag_err, timeout);
        end
    endtask

    task automatic test_p3;
        exp_q.delete();
        exp_q.push_back(mk(1, 98, 1));
        exp_q.push_back(mk(1, 99, 1));
        exp_q.push_back(mk(1, 99, 1));
        exp_q.push_back(mk(1, 99, 0));
        exp_q.push_back(mk(0, 0, 0));
        run_seq(3, 1, 0, 1, 0, -1);
        n_assert++;
        if (obs_q.size() !== 5) begin
            n_fail++;
            $display("FAIL p3_count: got %0d want 5", obs_q.size());
        end
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            n_assert++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL p3_bin%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_assert++;
        if (done_cyc !== 5 || ndone !== 1 || flag_err !== 0) begin
            n_fail++;
            $display("FAIL p3_done: got cyc=%0d n=%0d err=%0d want 5 1 0",
                     done_cyc, ndone, flag_err);
        end
    endtask

    task automatic test_b26;
        logic [9:0] tail;
        exp_q.delete();
        exp_q.push_back(mk(1, 100, 1));
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, 101, 1));
        tail = 10'b1111001101;
        for (int i = 9; i >= 0; i--) exp_q.push_back(mk(0, 0, tail[i]));
        run_seq(128 - 26, 0, 0, 1, 2, -1);
        n_assert++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL b26_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_assert++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b26_bin%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_assert++;
        if (ndone !== 1 || flag_err !== 0 || stall_err !== 0 || timeout !== 0) begin
            n_fail++;
            $display("FAIL b26_proto: got done=%0d ferr=%0d serr=%0d to=%0d want 1 0 0 0",
                     ndone, flag_err, stall_err, timeout);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] tail;
        exp_q.delete();
        exp_q.push_back(mk(1, 96, 1));
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, 97, 1));
        tail = 6'b110000;
        for (int i = 5; i >= 0; i--) exp_q.push_back(mk(0, 0, tail[i]));
        run_seq(8, 2, 1, 1, 1, -1);
        n_assert++;
        if (obs_q.size() !== 11) begin
            n_fail++;
            $display("FAIL stall_count: got %0d want 11", obs_q.size());
        end
        for (int i = 0; i < 11 && i < obs_q.size(); i++) begin
            n_assert++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stall_bin%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_assert++;
        if (stall_err !== 0 || ndone !== 1 || flag_err !== 0) begin
            n_fail++;
            $display("FAIL stall_hold: got serr=%0d done=%0d ferr=%0d want 0 1 0",
                     stall_err, ndone, flag_err);
        end
    endtask

    task automatic test_disabled;
        run_seq(37, 1, 1, 0, 0, -1);
        n_assert++;
        if (nrun !== 0 || obs_q.size() !== 0) begin
            n_fail++;
            $display("FAIL dis_run: got run_cycles=%0d bins=%0d want 0 0", nrun, obs_q.size());
        end
        n_assert++;
        if (done_cyc !== 0 || ndone !== 1) begin
            n_fail++;
            $display("FAIL dis_done: got cyc=%0d n=%0d want 0 1", done_cyc, ndone);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        run_seq(128 - 26, 0, 0, 1, 0, 7);
        #2 rst = 1'b1;
        #1;
        n_assert++;
        if ({ctx_dqp_addr, ctx_dqp_addr_vld, enc_run_dqp, EPMode_dqp, binVal,
             dqp_done_intr} !== 15'd0) begin
            n_fail++;
            $display("FAIL mid_reset_out: got %h want 0", {ctx_dqp_addr,
                     ctx_dqp_addr_vld, enc_run_dqp, EPMode_dqp, binVal, dqp_done_intr});
        end
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (dqp_done_intr || enc_run_dqp) seen++;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (dqp_done_intr || enc_run_dqp) seen++;
        end
        n_assert++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL mid_no_done: got %0d active cycles want 0", seen);
        end
        exp_q.delete();
        exp_q.push_back(mk(1, 96, 1));
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, 97, 1));
        exp_q.push_back(mk(0, 0, 0));
        exp_q.push_back(mk(0, 0, 1));
        run_seq(128 - 5, 2, 0, 1, 0, -1);
        n_assert++;
        if (obs_q.size() !== 7) begin
            n_fail++;
            $display("FAIL m5_count: got %0d want 7", obs_q.size());
        end
        for (int i = 0; i < 7 && i < obs_q.size(); i++) begin
            n_assert++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL m5_bin%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        int v, st, md, bad;
        bit cif, en;
        for (int t = 0; t < 60; t++) begin
            v = $urandom_range(0, 127);
            if (t == 0) v = 64;
            if (t == 1) v = 63;
            st = $urandom_range(0, 2);
            cif = 1'($urandom);
            en = ($urandom_range(0, 9) != 0);
            md = $urandom_range(0, 2);
            build_exp(v, st, cif, en);
            run_seq(v, st, cif, en, md, -1);
            bad = 0;
            if (obs_q.size() != exp_q.size()) bad++;
            else foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad++;
            n_assert++;
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL rnd%0d_bins: v=%0d st=%0d cif=%0b got n=%0d want n=%0d bad=%0d",
                         t, v, st, cif, obs_q.size(), exp_q.size(), bad);
            end
            n_assert++;
            if (ndone !== 1 || stall_err !== 0 || flag_err !== 0 || timeout !== 0) begin
                n_fail++;
                $display("FAIL rnd%0d_proto: got done=%0d serr=%0d ferr=%0d to=%0d want 1 0 0 0",
                         t, ndone, stall_err, flag_err, timeout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_i();
        test_p3();
        test_b26();
        test_back_to_back();
        test_disabled();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
